// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared accumulator width, word type and reset value
package acc_pkg;

  localparam int ACC_WIDTH = 16;

  typedef logic [ACC_WIDTH-1:0] acc_word_t;

  localparam acc_word_t ACC_RESET_VAL = '0;

endpackage

// File: rtl/acc_flags.sv
// rtl/acc_flags.sv - combinational sign/zero (and optional parity) decode of a stored word
//
// Optional feature macro: ACC_REG_PARITY_EN (adds the parity output)
//
// Ports:
//   value   in   WIDTH  stored register value to decode
//   sign    out  1      value[WIDTH-1]
//   zero    out  1      1 when value == 0
//   parity  out  1      even-parity bit ^value (only with ACC_REG_PARITY_EN)
module acc_flags
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic             sign,
  output logic             zero
`ifdef ACC_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  assign sign = value[WIDTH-1];
  assign zero = ~|value;

`ifdef ACC_REG_PARITY_EN
  assign parity = ^value;
`endif

endmodule

// File: rtl/acc_reg.sv
// rtl/acc_reg.sv - enabled accumulator register with sign/zero status flags
//
// Optional feature macro: ACC_REG_PARITY_EN (adds the accp output)
//
// Ports:
//   clk    in   1      system clock, all updates on the rising edge
//   rst_n  in   1      synchronous active-low reset, clears the register
//   accce  in   1      load enable, alu is captured on the next rising edge
//   alu    in   WIDTH  ALU result to load
//   acc    out  WIDTH  registered accumulator contents
//   acc15  out  1      sign flag, acc[WIDTH-1]
//   accz   out  1      zero flag, 1 when acc == 0
//   accp   out  1      even parity of acc (only with ACC_REG_PARITY_EN)
//
// WIDTH must be >= 2.
module acc_reg
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accce,
  input  logic [WIDTH-1:0] alu,
  output logic [WIDTH-1:0] acc,
  output logic             acc15,
  output logic             accz
`ifdef ACC_REG_PARITY_EN
  ,
  output logic             accp
`endif
);

  logic [WIDTH-1:0] acc_q;

  // Reset beats a pending load; with accce low the register holds, so
  // alu (even undefined) never reaches acc_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= WIDTH'(ACC_RESET_VAL);
    end else if (accce) begin
      acc_q <= alu;
    end
  end

  assign acc = acc_q;

  // Flags decode the register only, so they move with acc and never
  // follow alu.
  acc_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .value  (acc_q),
    .sign   (acc15),
    .zero   (accz)
`ifdef ACC_REG_PARITY_EN
    ,
    .parity (accp)
`endif
  );

endmodule

// File: tb/tb_acc_reg.sv
// tb/tb_acc_reg.sv - self-checking bench for acc_reg
module tb_acc_reg;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         accce;
  logic [W-1:0] alu;
  logic [W-1:0] acc;
  logic         acc15;
  logic         accz;
  logic         obs_p;

`ifdef ACC_REG_PARITY_EN
  logic accp;
  assign obs_p = accp;
`else
  assign obs_p = 1'b0;
`endif

  logic [W+2:0] obs;
  assign obs = {acc, acc15, accz, obs_p};

  int n_pass  = 0;
  int n_total = 0;

  // Reference value of the accumulator as the spec's rules dictate.
  logic [W-1:0] model;

  always #5 clk = ~clk;

  acc_reg #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .accce (accce),
    .alu   (alu),
    .acc   (acc),
    .acc15 (acc15),
    .accz  (accz)
`ifdef ACC_REG_PARITY_EN
    ,
    .accp  (accp)
`endif
  );

  // Expected {acc, sign, zero, parity} for a stored value, from arithmetic.
  function automatic logic [W+2:0] expect_of(input logic [W-1:0] v);
    logic s, z, p;
    s = (int'(v) >= (1 << (W - 1)));
    z = (int'(v) == 0);
    p = 1'b0;
`ifdef ACC_REG_PARITY_EN
    p = ($countones(v) % 2) == 1;
`endif
    return {v, s, z, p};
  endfunction

  // One rising edge; the model applies reset > load > hold, then sample #1 later.
  task automatic step();
    @(posedge clk);
    if (rst_n === 1'b0) model = '0;
    else if (accce === 1'b1) model = alu;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; accce = 1'b1; alu = 16'hFFFF;
    step();
    step();
    n_total++;
    if (obs !== expect_of(16'h0000))
      $display("FAIL reset: acc/flags=%h expected %h", obs, expect_of(16'h0000));
    else n_pass++;
  endtask

  task automatic test_load_positive();
    rst_n = 1'b1; accce = 1'b1; alu = 16'h0003;
    step();
    n_total++;
    if (obs !== expect_of(16'h0003))
      $display("FAIL load_pos: acc/flags=%h expected %h", obs, expect_of(16'h0003));
    else n_pass++;
    accce = 1'b0; alu = 16'h1234;
    step();
    step();
    n_total++;
    if (obs !== expect_of(16'h0003))
      $display("FAIL load_pos_hold: acc/flags=%h expected %h", obs, expect_of(16'h0003));
    else n_pass++;
  endtask

  task automatic test_load_negative();
    accce = 1'b1; alu = 16'h8001;
    step();
    n_total++;
    if (obs !== expect_of(16'h8001))
      $display("FAIL load_neg: acc/flags=%h expected %h", obs, expect_of(16'h8001));
    else n_pass++;
    accce = 1'b0; alu = 16'h0000;
    step();
    n_total++;
    if (obs !== expect_of(16'h8001))
      $display("FAIL load_neg_hold: acc/flags=%h expected %h", obs, expect_of(16'h8001));
    else n_pass++;
  endtask

  task automatic test_load_zero();
    accce = 1'b1; alu = 16'h0000;
    step();
    n_total++;
    if (obs !== expect_of(16'h0000))
      $display("FAIL load_zero: acc/flags=%h expected %h", obs, expect_of(16'h0000));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seq [3];
    seq[0] = 16'h0001; seq[1] = 16'h0002; seq[2] = 16'hFFFF;
    accce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu = seq[i];
      step();
      n_total++;
      if (obs !== expect_of(seq[i]))
        $display("FAIL back_to_back[%0d]: acc/flags=%h expected %h", i, obs, expect_of(seq[i]));
      else n_pass++;
    end
    accce = 1'b0;
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b1; accce = 1'b1; alu = 16'h8001;
    step();
    n_total++;
    if (obs !== expect_of(16'h8001))
      $display("FAIL rstpri_load: acc/flags=%h expected %h", obs, expect_of(16'h8001));
    else n_pass++;
`ifdef ACC_REG_PARITY_EN
    n_total++;
    if (accp !== 1'b0) $display("FAIL parity_8001: accp=%b expected 0", accp);
    else n_pass++;
`endif
    rst_n = 1'b0; accce = 1'b1; alu = 16'h0005;
    step();
    n_total++;
    if (obs !== expect_of(16'h0000))
      $display("FAIL rstpri_reset: acc/flags=%h expected %h", obs, expect_of(16'h0000));
    else n_pass++;
    rst_n = 1'b1; accce = 1'b0;
    step();
    n_total++;
    if (obs !== expect_of(16'h0000))
      $display("FAIL rstpri_idle: acc/flags=%h expected %h", obs, expect_of(16'h0000));
    else n_pass++;
    accce = 1'b1; alu = 16'h0001;
    step();
    n_total++;
    if (obs !== expect_of(16'h0001))
      $display("FAIL rstpri_resume: acc/flags=%h expected %h", obs, expect_of(16'h0001));
    else n_pass++;
`ifdef ACC_REG_PARITY_EN
    n_total++;
    if (accp !== 1'b1) $display("FAIL parity_0001: accp=%b expected 1", accp);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      accce = $urandom_range(0, 1) == 1;
      alu   = accce ? W'($urandom) : 'x;
      step();
      n_total++;
      if (obs !== expect_of(model)) begin
        if (errs < 10)
          $display("FAIL random[%0d]: acc/flags=%h expected %h", i, obs, expect_of(model));
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    accce = 1'b0;
    alu   = '0;
    model = 'x;
    test_reset();
    test_load_positive();
    test_load_negative();
    test_load_zero();
    test_back_to_back();
    test_reset_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
